// File: rtl/request_queue_pkg.sv
// Shared types and constants for the request queue: parser op encoding,
// the parser output bundle and the stored queue entry layout.
package global_defs;

  localparam int QUEUE_SIZE    = 16;
  localparam int ADDRESS_WIDTH = 32;
  localparam int AGE_LIMIT     = 100;

  typedef enum logic [2:0] {
    NOP        = 3'd0,
    DATA_READ  = 3'd1,
    DATA_WRITE = 3'd2,
    INST_FETCH = 3'd3,
    INVALIDATE = 3'd4,
    SNOOP      = 3'd5
  } parsed_op_t;

  typedef struct packed {
    logic                     op_ready_s;
    parsed_op_t               opcode;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [31:0]              time_cpu;
  } parser_out_struct_t;

  // Sized to hold AGE_LIMIT itself so the counter can saturate there.
  typedef logic [$clog2(AGE_LIMIT+1)-1:0] age_counter_t;

  typedef struct packed {
    parsed_op_t               opcode;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [31:0]              time_cpu;
    age_counter_t             age;
  } queue_entry_t;

endpackage

// File: rtl/request_queue_if.sv
// Parser-side push handshake and scheduler-side head/pop view of the queue.
interface request_queue_if #(
  parameter int QUEUE_SIZE = global_defs::QUEUE_SIZE
);

  global_defs::parser_out_struct_t             parser_in;
  logic                                        queue_full;
  logic                                        pop;
  logic                                        head_valid;
  global_defs::parsed_op_t                     head_op;
  logic [global_defs::ADDRESS_WIDTH-1:0]       head_address;
  logic [31:0]                                 head_time;
  global_defs::age_counter_t                   head_age;
  logic                                        head_aged;
  logic [$clog2(QUEUE_SIZE+1)-1:0]             occupancy;
  logic                                        overflow;

  modport master (
    output parser_in, pop,
    input  queue_full, head_valid, head_op, head_address, head_time,
           head_age, head_aged, occupancy, overflow
  );

  modport slave (
    input  parser_in, pop,
    output queue_full, head_valid, head_op, head_address, head_time,
           head_age, head_aged, occupancy, overflow
  );

endinterface

// File: rtl/request_queue.sv
// Circular FIFO of parsed requests with per-entry saturating age counters,
// registered full/occupancy status and a sticky overflow flag.
module request_queue #(
  parameter int QUEUE_SIZE = global_defs::QUEUE_SIZE,
  parameter int AGE_LIMIT  = global_defs::AGE_LIMIT
) (
  input logic            clk,
  input logic            rst,
  request_queue_if.slave bus
);

  localparam int PTR_W = $clog2(QUEUE_SIZE);
  localparam int OCC_W = $clog2(QUEUE_SIZE+1);

  global_defs::queue_entry_t entries_q [QUEUE_SIZE];
  global_defs::queue_entry_t entries_d [QUEUE_SIZE];
  logic [PTR_W-1:0]          head_q, head_d, tail_q, tail_d;
  logic [OCC_W-1:0]          occupancy_q, occupancy_d;
  logic                      queue_full_q, queue_full_d;
  logic                      overflow_q, overflow_d;
  logic                      strobe, push, pop_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_SIZE-1)) ? '0 : p + 1'b1;
  endfunction

  // Slot idx is live when its distance from head (mod QUEUE_SIZE) is below occupancy.
  function automatic logic entry_live(input int idx, input logic [PTR_W-1:0] head,
                                      input logic [OCC_W-1:0] occ);
    int off;
    off = (idx >= int'(head)) ? idx - int'(head) : idx + QUEUE_SIZE - int'(head);
    return off < int'(occ);
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    strobe       = bus.parser_in.op_ready_s && (bus.parser_in.opcode != global_defs::NOP);
    push         = strobe && !queue_full_q;
    pop_en       = bus.pop && (occupancy_q != '0);
    entries_d    = entries_q;
    head_d       = pop_en ? ptr_inc(head_q) : head_q;
    tail_d       = push ? ptr_inc(tail_q) : tail_q;
    occupancy_d  = occupancy_q;
    overflow_d   = overflow_q | (strobe && queue_full_q);

    for (int i = 0; i < QUEUE_SIZE; i++) begin
      if (entry_live(i, head_q, occupancy_q) &&
          entries_q[i].age < global_defs::age_counter_t'(AGE_LIMIT)) begin
        entries_d[i].age = entries_q[i].age + 1'b1;
      end
    end

    if (push) begin
      entries_d[tail_q] = '{opcode:   bus.parser_in.opcode,
                            address:  bus.parser_in.address,
                            time_cpu: bus.parser_in.time_cpu,
                            age:      '0};
    end

    case ({push, pop_en})
      2'b10:   occupancy_d = occupancy_q + 1'b1;
      2'b01:   occupancy_d = occupancy_q - 1'b1;
      default: occupancy_d = occupancy_q;
    endcase
    queue_full_d = (occupancy_d == OCC_W'(QUEUE_SIZE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      occupancy_q  <= '0;
      queue_full_q <= 1'b0;
      overflow_q   <= 1'b0;
      // NOTE: only the ages are cleared; payload fields are don't-care until
      // written, since liveness comes from head/occupancy, not the storage.
      for (int i = 0; i < QUEUE_SIZE; i++) entries_q[i].age <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      occupancy_q  <= occupancy_d;
      queue_full_q <= queue_full_d;
      overflow_q   <= overflow_d;
      entries_q    <= entries_d;
    end
  end

  assign bus.head_valid   = (occupancy_q != '0);
  assign bus.head_op      = bus.head_valid ? entries_q[head_q].opcode   : global_defs::NOP;
  assign bus.head_address = bus.head_valid ? entries_q[head_q].address  : '0;
  assign bus.head_time    = bus.head_valid ? entries_q[head_q].time_cpu : '0;
  assign bus.head_age     = bus.head_valid ? entries_q[head_q].age      : '0;
  assign bus.head_aged    = bus.head_valid &&
                            (entries_q[head_q].age >= global_defs::age_counter_t'(AGE_LIMIT));
  assign bus.queue_full   = queue_full_q;
  assign bus.occupancy    = occupancy_q;
  assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_request_queue.sv
// Scoreboard bench for request_queue: expected entries are queued as strobes
// are driven and compared against the head as the queue drains.
module tb_request_queue;
  import global_defs::*;

  localparam int OCC_W = $clog2(QUEUE_SIZE+1);

  typedef struct {
    parsed_op_t  op;
    logic [31:0] addr;
    logic [31:0] tm;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic exp_overflow = 1'b0;

  request_queue_if #(.QUEUE_SIZE(QUEUE_SIZE)) bus ();

  request_queue #(.QUEUE_SIZE(QUEUE_SIZE), .AGE_LIMIT(AGE_LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one strobe (optionally with pop) for a single cycle and updates the model.
  task automatic strobe(input parsed_op_t op, input logic [31:0] addr,
                        input logic [31:0] tm, input logic do_pop);
    logic accept, popping;
    accept  = (op != NOP) && (exp_q.size() < QUEUE_SIZE);
    popping = do_pop && (exp_q.size() != 0);
    bus.parser_in = '{op_ready_s: 1'b1, opcode: op, address: addr, time_cpu: tm};
    bus.pop = do_pop;
    step();
    bus.parser_in = '0;
    bus.pop = 1'b0;
    if (popping) void'(exp_q.pop_front());
    if (accept) exp_q.push_back('{op, addr, tm});
    if (op != NOP && !accept) exp_overflow = 1'b1;
  endtask

  task automatic compare_head(input string tag);
    logic             want_valid;
    parsed_op_t       want_op;
    logic [31:0]      want_addr, want_tm;
    want_valid = (exp_q.size() != 0);
    want_op    = want_valid ? exp_q[0].op   : NOP;
    want_addr  = want_valid ? exp_q[0].addr : 32'h0;
    want_tm    = want_valid ? exp_q[0].tm   : 32'h0;
    checks++;
    if (bus.occupancy !== OCC_W'(exp_q.size())) begin
      errors++; $display("FAIL %s occupancy: got %0d expected %0d", tag, bus.occupancy, exp_q.size());
    end
    checks++;
    if (bus.queue_full !== (exp_q.size() == QUEUE_SIZE)) begin
      errors++; $display("FAIL %s queue_full: got %b expected %b", tag, bus.queue_full, exp_q.size() == QUEUE_SIZE);
    end
    checks++;
    if (bus.overflow !== exp_overflow) begin
      errors++; $display("FAIL %s overflow: got %b expected %b", tag, bus.overflow, exp_overflow);
    end
    checks++;
    if (bus.head_valid !== want_valid) begin
      errors++; $display("FAIL %s head_valid: got %b expected %b", tag, bus.head_valid, want_valid);
    end
    checks++;
    if (bus.head_op !== want_op) begin
      errors++; $display("FAIL %s head_op: got %0d expected %0d", tag, bus.head_op, want_op);
    end
    checks++;
    if (bus.head_address !== want_addr) begin
      errors++; $display("FAIL %s head_address: got %h expected %h", tag, bus.head_address, want_addr);
    end
    checks++;
    if (bus.head_time !== want_tm) begin
      errors++; $display("FAIL %s head_time: got %0d expected %0d", tag, bus.head_time, want_tm);
    end
  endtask

  task automatic pop_check(input string tag);
    compare_head(tag);
    bus.pop = 1'b1;
    step();
    bus.pop = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    exp_overflow = 1'b0;
  endtask

  task automatic test_reset();
    // Strobe and pop during reset must both be ignored.
    rst = 1'b1;
    bus.parser_in = '{op_ready_s: 1'b1, opcode: DATA_READ, address: 32'h55, time_cpu: 32'd9};
    bus.pop = 1'b1;
    step();
    step();
    rst = 1'b0;
    bus.parser_in = '0;
    bus.pop = 1'b0;
    exp_q.delete();
    exp_overflow = 1'b0;
    compare_head("reset");
    bus.pop = 1'b1;
    step();
    bus.pop = 1'b0;
    compare_head("pop_empty");
  endtask

  task automatic test_first_push();
    do_reset();
    strobe(DATA_READ, 32'h0000_1000, 32'd5, 1'b0);
    compare_head("first_push");
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 0; i < QUEUE_SIZE; i++) strobe(DATA_WRITE, 32'(i), 32'(i + 7), 1'b0);
    compare_head("filled");
    strobe(DATA_READ, 32'h999, 32'd1, 1'b0);
    compare_head("overflow");
    for (int i = 0; i < QUEUE_SIZE; i++) pop_check("drain_full");
    compare_head("drained_full");
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < QUEUE_SIZE; i++) strobe(INST_FETCH, 32'(i), 32'(100 + i), 1'b0);
    for (int i = 0; i < 4; i++) pop_check("wrap_pop");
    for (int i = 0; i < 4; i++) strobe(DATA_WRITE, 32'h100 + 32'(i), 32'(200 + i), 1'b0);
    compare_head("wrap_refill");
    for (int i = 0; i < QUEUE_SIZE; i++) pop_check("wrap_drain");
    compare_head("wrap_empty");
  endtask

  task automatic test_aging();
    int want;
    do_reset();
    strobe(SNOOP, 32'hABC, 32'd3, 1'b0);
    for (int k = 0; k <= 150; k++) begin
      want = (k < AGE_LIMIT) ? k : AGE_LIMIT;
      checks++;
      if (bus.head_age !== age_counter_t'(want)) begin
        errors++; $display("FAIL age k=%0d: got %0d expected %0d", k, bus.head_age, want);
      end
      checks++;
      if (bus.head_aged !== (k >= AGE_LIMIT)) begin
        errors++; $display("FAIL aged k=%0d: got %b expected %b", k, bus.head_aged, k >= AGE_LIMIT);
      end
      step();
    end
    compare_head("aging_end");
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 3; i++) strobe(DATA_READ, 32'h10 + 32'(i), 32'(50 + i), 1'b0);
    compare_head("simul_pre");
    strobe(DATA_WRITE, 32'h13, 32'd53, 1'b1);
    compare_head("simul_push_pop");
    strobe(NOP, 32'hDEAD, 32'd0, 1'b0);
    compare_head("simul_nop");
    for (int i = 0; i < 3; i++) pop_check("simul_drain");
    compare_head("simul_empty");
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int i = 0; i < 10; i++) strobe(INVALIDATE, 32'h40 + 32'(i), 32'(i), 1'b0);
    strobe(DATA_READ, 32'h1, 32'd1, 1'b0);
    compare_head("pre_reset");
    rst = 1'b1;
    bus.parser_in = '{op_ready_s: 1'b1, opcode: DATA_READ, address: 32'h77, time_cpu: 32'd4};
    step();
    rst = 1'b0;
    bus.parser_in = '0;
    exp_q.delete();
    exp_overflow = 1'b0;
    compare_head("midflight_reset");
  endtask

  initial begin
    rst = 1'b1;
    bus.parser_in = '0;
    bus.pop = 1'b0;
    test_reset();
    test_first_push();
    test_fill_overflow();
    test_wrap();
    test_aging();
    test_simultaneous();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
